// File: rtl/multi_cycle_ctrl_if.sv
// Control/status bundle between the multi-cycle controller (master) and the
// datapath/memory side (slave).
interface multi_cycle_ctrl_if;
    logic [31:0] inst;
    logic        imem_ready;
    logic        dmem_ready;
    logic        ir_wen;
    logic        pc_wen;
    logic        rf_wen;
    logic        dm_req;
    logic [3:0]  dm_wen;
    logic [2:0]  state;
    logic        inst_done;
    logic [31:0] cycle_cnt;
    logic [31:0] inst_cnt;

    modport master (
        input  inst, imem_ready, dmem_ready,
        output ir_wen, pc_wen, rf_wen, dm_req, dm_wen, state, inst_done,
               cycle_cnt, inst_cnt
    );

    modport slave (
        output inst, imem_ready, dmem_ready,
        input  ir_wen, pc_wen, rf_wen, dm_req, dm_wen, state, inst_done,
               cycle_cnt, inst_cnt
    );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Five-state (IF/ID/EX/MEM/WB) control FSM for a multi-cycle MIPS-like core.
// Define MULTI_CYCLE_PERF_CNT_EN to build the cycle/instruction counters.
module multi_cycle_ctrl (
    input  logic               clk,
    input  logic               resetn,
    multi_cycle_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        C_ALU = 3'd0,
        C_LD  = 3'd1,
        C_ST  = 3'd2,
        C_BR  = 3'd3,
        C_INV = 3'd4
    } cls_e;

    state_e state_q, state_d;
    cls_e   cls_q, cls_d;
    cls_e   inst_cls;

    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] sa;
    logic [5:0] funct;
    logic       unused_inst_bits;

    logic       ir_wen_c;
    logic       pc_wen_c;
    logic       rf_wen_c;
    logic       dm_req_c;
    logic [3:0] dm_wen_c;
    logic       inst_done_c;

    assign op               = bus.inst[31:26];
    assign rs               = bus.inst[25:21];
    assign sa               = bus.inst[10:6];
    assign funct            = bus.inst[5:0];
    assign unused_inst_bits = ^bus.inst[20:11];

    // Instruction class; only sampled into cls_q while in ID.
    always_comb begin
        inst_cls = C_INV;
        case (op)
            6'b000010, 6'b000100, 6'b000101: inst_cls = C_BR;
            6'b100011:                       inst_cls = C_LD;
            6'b101011:                       inst_cls = C_ST;
            6'b001001, 6'b001111, 6'b100010: inst_cls = C_ALU;
            6'b000000: begin
                case (funct)
                    6'b100001, 6'b100011, 6'b101010, 6'b100100, 6'b100111,
                    6'b100101, 6'b100110, 6'b010001, 6'b010101: begin
                        if (sa == 5'd0) inst_cls = C_ALU;
                    end
                    6'b000000, 6'b000010: begin
                        if (rs == 5'd0) inst_cls = C_ALU;
                    end
                    default: inst_cls = C_INV;
                endcase
            end
            default: inst_cls = C_INV;
        endcase
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would otherwise infer a latch.
        state_d     = S_IF;
        cls_d       = cls_q;
        ir_wen_c    = 1'b0;
        pc_wen_c    = 1'b0;
        rf_wen_c    = 1'b0;
        dm_req_c    = 1'b0;
        dm_wen_c    = 4'h0;
        inst_done_c = 1'b0;

        case (state_q)
            S_IF: begin
                ir_wen_c = bus.imem_ready;
                state_d  = bus.imem_ready ? S_ID : S_IF;
            end
            S_ID: begin
                cls_d = inst_cls;
                if (inst_cls == C_BR || inst_cls == C_INV) begin
                    pc_wen_c    = 1'b1;
                    inst_done_c = 1'b1;
                    state_d     = S_IF;
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                state_d = (cls_q == C_LD || cls_q == C_ST) ? S_MEM : S_WB;
            end
            S_MEM: begin
                dm_req_c = 1'b1;
                dm_wen_c = (cls_q == C_ST) ? 4'hF : 4'h0;
                if (!bus.dmem_ready) begin
                    state_d = S_MEM;
                end else if (cls_q == C_ST) begin
                    pc_wen_c    = 1'b1;
                    inst_done_c = 1'b1;
                    state_d     = S_IF;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                rf_wen_c    = 1'b1;
                pc_wen_c    = 1'b1;
                inst_done_c = 1'b1;
                state_d     = S_IF;
            end
            default: state_d = S_IF;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (!resetn) begin
            state_q <= S_IF;
            cls_q   <= C_INV;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
        end
    end

    // Strobes are gated combinationally so nothing fires during reset.
    assign bus.ir_wen    = resetn & ir_wen_c;
    assign bus.pc_wen    = resetn & pc_wen_c;
    assign bus.rf_wen    = resetn & rf_wen_c;
    assign bus.dm_req    = resetn & dm_req_c;
    assign bus.dm_wen    = resetn ? dm_wen_c : 4'h0;
    assign bus.inst_done = resetn & inst_done_c;
    assign bus.state     = state_q;

`ifdef MULTI_CYCLE_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] inst_cnt_q, inst_cnt_d;

    always_comb begin
        cycle_cnt_d = cycle_cnt_q + 32'd1;
        inst_cnt_d  = inst_cnt_q + {31'd0, inst_done_c};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cycle_cnt_q <= 32'd0;
            inst_cnt_q  <= 32'd0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            inst_cnt_q  <= inst_cnt_d;
        end
    end

    assign bus.cycle_cnt = cycle_cnt_q;
    assign bus.inst_cnt  = inst_cnt_q;
`else
    assign bus.cycle_cnt = 32'd0;
    assign bus.inst_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: per-instruction phase-list model,
// directed latency/strobe cases and a randomized run with random resets.
`timescale 1ns/1ps
module tb_multi_cycle_ctrl;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    multi_cycle_ctrl_if bus ();

    multi_cycle_ctrl dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

`ifdef MULTI_CYCLE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam int K_ALU = 0;
    localparam int K_LD  = 1;
    localparam int K_ST  = 2;
    localparam int K_BR  = 3;
    localparam int K_INV = 4;

    typedef struct {
        logic [31:0] inst;
        int          im_st;
        int          dm_st;
        bit          rnd;
    } job_t;

    typedef struct packed {
        logic [2:0] st;
        logic       rf;
        logic       pc;
        logic       req;
        logic [3:0] wen;
    } tr_t;

    int          n_checks = 0;
    int          n_err    = 0;
    job_t        pend[$];
    tr_t         trace[$];
    int          lat_q[$];
    int          plan[5];
    int          plan_len  = 0;
    int          idx       = 0;
    int          cur_cls   = K_INV;
    logic [31:0] cur_inst  = 32'd0;
    int          im_left   = 0;
    int          dm_left   = 0;
    bit          cur_rnd   = 1'b1;
    bit          need_new  = 1'b1;
    int          jobs_done = 0;
    int          dut_lat   = 0;
    logic [31:0] exp_cyc   = 32'd0;
    logic [31:0] exp_ins   = 32'd0;
    logic [31:0] obs_cyc   = 32'd0;
    logic [31:0] obs_ins   = 32'd0;
    logic [2:0]  obs_state = 3'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int class_of(input logic [31:0] w);
        logic [5:0] op;
        logic [5:0] fn;
        op = w[31:26];
        fn = w[5:0];
        if (op inside {6'h02, 6'h04, 6'h05}) return K_BR;
        if (op == 6'h23) return K_LD;
        if (op == 6'h2B) return K_ST;
        if (op inside {6'h09, 6'h0F, 6'h22}) return K_ALU;
        if (op == 6'h00 && w[10:6] == 5'd0 &&
            fn inside {6'h21, 6'h23, 6'h2A, 6'h24, 6'h27, 6'h25, 6'h26, 6'h11, 6'h15})
            return K_ALU;
        if (op == 6'h00 && w[25:21] == 5'd0 && fn inside {6'h00, 6'h02}) return K_ALU;
        return K_INV;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        logic [5:0]  ops [8];
        logic [5:0]  fns [11];
        ops = '{6'h02, 6'h04, 6'h05, 6'h23, 6'h2B, 6'h09, 6'h0F, 6'h22};
        fns = '{6'h21, 6'h23, 6'h2A, 6'h24, 6'h27, 6'h25, 6'h26, 6'h11, 6'h15, 6'h00, 6'h02};
        w = $urandom();
        case ($urandom_range(0, 3))
            0: w = w;
            2: begin
                w[31:26] = 6'h00;
                w[5:0]   = fns[$urandom_range(0, 10)];
                if ($urandom_range(0, 1) == 1) w[10:6]  = 5'd0;
                if ($urandom_range(0, 1) == 1) w[25:21] = 5'd0;
            end
            default: w[31:26] = ops[$urandom_range(0, 7)];
        endcase
        return w;
    endfunction

    task automatic push_job(input logic [31:0] inst, input int im_st, input int dm_st);
        job_t j;
        j.inst  = inst;
        j.im_st = im_st;
        j.dm_st = dm_st;
        j.rnd   = 1'b0;
        pend.push_back(j);
    endtask

    task automatic start_instr();
        job_t j;
        if (pend.size() > 0) begin
            j = pend.pop_front();
        end else begin
            j.inst  = rand_inst();
            j.im_st = 0;
            j.dm_st = 0;
            j.rnd   = 1'b1;
        end
        cur_inst = j.inst;
        im_left  = j.im_st;
        dm_left  = j.dm_st;
        cur_rnd  = j.rnd;
        cur_cls  = class_of(cur_inst);
        case (cur_cls)
            K_ALU:   begin plan = '{0, 1, 2, 4, 0}; plan_len = 4; end
            K_LD:    begin plan = '{0, 1, 2, 3, 4}; plan_len = 5; end
            K_ST:    begin plan = '{0, 1, 2, 3, 0}; plan_len = 4; end
            default: begin plan = '{0, 1, 0, 0, 0}; plan_len = 2; end
        endcase
        idx      = 0;
        need_new = 1'b0;
    endtask

    // One clock cycle: drive inputs, compare every output, advance the model.
    task automatic cycle(input logic rn);
        int   ph;
        bit   im, dm, stalled, last, done;
        tr_t  t;
        @(negedge clk);
        if (need_new) start_instr();
        ph = plan[idx];
        if (cur_rnd) begin
            im = ($urandom_range(0, 3) != 0);
            dm = ($urandom_range(0, 2) != 0);
        end else begin
            im = (ph == 0) ? (im_left == 0) : ($urandom_range(0, 1) == 1);
            dm = (ph == 3) ? (dm_left == 0) : ($urandom_range(0, 1) == 1);
        end
        resetn         = rn;
        bus.imem_ready = im;
        bus.dmem_ready = dm;
        bus.inst       = (ph == 1) ? cur_inst : $urandom();
        #1;
        stalled = (ph == 0 && !im) || (ph == 3 && !dm);
        last    = (idx == plan_len - 1);
        done    = rn && last && !stalled;

        check("state",     32'(bus.state),     32'(ph));
        check("ir_wen",    32'(bus.ir_wen),    32'(rn && ph == 0 && im));
        check("pc_wen",    32'(bus.pc_wen),    32'(done));
        check("inst_done", 32'(bus.inst_done), 32'(done));
        check("rf_wen",    32'(bus.rf_wen),    32'(rn && ph == 4));
        check("dm_req",    32'(bus.dm_req),    32'(rn && ph == 3));
        check("dm_wen",    32'(bus.dm_wen),    (rn && ph == 3 && cur_cls == K_ST) ? 32'hF : 32'h0);
        check("cycle_cnt", bus.cycle_cnt,      PERF ? exp_cyc : 32'd0);
        check("inst_cnt",  bus.inst_cnt,       PERF ? exp_ins : 32'd0);

        obs_cyc   = bus.cycle_cnt;
        obs_ins   = bus.inst_cnt;
        obs_state = bus.state;
        t.st  = bus.state;
        t.rf  = bus.rf_wen;
        t.pc  = bus.pc_wen;
        t.req = bus.dm_req;
        t.wen = bus.dm_wen;
        trace.push_back(t);

        if (!rn) begin
            exp_cyc  = 32'd0;
            exp_ins  = 32'd0;
            need_new = 1'b1;
            dut_lat  = 0;
        end else begin
            dut_lat++;
            if (bus.inst_done === 1'b1) begin
                lat_q.push_back(dut_lat);
                dut_lat = 0;
            end
            exp_cyc = exp_cyc + 32'd1;
            if (done) exp_ins = exp_ins + 32'd1;
            if (ph == 0 && !im && im_left > 0) im_left--;
            if (ph == 3 && !dm && dm_left > 0) dm_left--;
            if (!stalled) begin
                if (last) begin
                    need_new = 1'b1;
                    jobs_done++;
                end else begin
                    idx++;
                end
            end
        end
    endtask

    task automatic run_jobs(input int k);
        int target;
        int guard;
        target = jobs_done + k;
        guard  = 0;
        trace.delete();
        lat_q.delete();
        while (jobs_done < target && guard < 300) begin
            cycle(1'b1);
            guard++;
        end
        if (jobs_done < target) begin
            n_checks++;
            n_err++;
            $display("FAIL run_jobs timeout: done %0d, required %0d", jobs_done, target);
        end
    endtask

    function automatic int count(input int sel);
        int n;
        n = 0;
        foreach (trace[k]) begin
            case (sel)
                0:       n += int'(trace[k].rf);
                1:       n += int'(trace[k].pc);
                2:       n += int'(trace[k].req);
                default: n += int'(trace[k].wen != 4'h0);
            endcase
        end
        return n;
    endfunction

    function automatic int lat_at(input int k);
        return (lat_q.size() > k) ? lat_q[k] : -1;
    endfunction

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int addu_st [4];
        int guard;
        addu_st = '{0, 1, 2, 4};

        bus.inst       = 32'd0;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        resetn         = 1'b0;
        repeat (2) @(posedge clk);
        repeat (3) cycle(1'b0);

        // ADDU with ready inputs high
        push_job(32'h00221821, 0, 0);
        run_jobs(1);
        check("addu_cycles", 32'(trace.size()), 32'd4);
        for (int k = 0; k < 4 && k < trace.size(); k++) begin
            check("addu_state_seq", 32'(trace[k].st), 32'(addu_st[k]));
            check("addu_rf_seq",    32'(trace[k].rf), 32'(k == 3));
        end
        check("addu_lat", 32'(lat_at(0)), 32'd4);

        // LW with dmem_ready low for two MEM cycles
        push_job(32'h8C030004, 0, 2);
        run_jobs(1);
        check("lw_lat",      32'(lat_at(0)), 32'd7);
        check("lw_mem_reqs", 32'(count(2)),  32'd3);
        check("lw_dm_wen",   32'(count(3)),  32'd0);
        check("lw_rf_once",  32'(count(0)),  32'd1);

        // SW with ready inputs high
        push_job(32'hAC030008, 0, 0);
        run_jobs(1);
        check("sw_lat",     32'(lat_at(0)), 32'd4);
        check("sw_wen_cyc", 32'(count(3)),  32'd1);
        check("sw_rf",      32'(count(0)),  32'd0);
        check("sw_pc_once", 32'(count(1)),  32'd1);
        if (trace.size() == 4) begin
            check("sw_wen_in_mem", 32'(trace[3].wen), 32'hF);
            check("sw_pc_in_mem",  32'(trace[3].pc),  32'd1);
        end else begin
            check("sw_trace_len", 32'(trace.size()), 32'd4);
        end

        // BEQ followed by an invalid encoding
        push_job(32'h10220003, 0, 0);
        push_job(32'hFFFFFFFF, 0, 0);
        run_jobs(2);
        check("beq_lat",    32'(lat_at(0)), 32'd2);
        check("inv_lat",    32'(lat_at(1)), 32'd2);
        check("br_inv_pc",  32'(count(1)),  32'd2);
        check("br_inv_rf",  32'(count(0)),  32'd0);
        check("br_inv_wen", 32'(count(3)),  32'd0);

        // Fetch stall: three cycles of imem_ready low
        push_job(32'h00221821, 3, 0);
        run_jobs(1);
        check("if_stall_lat", 32'(lat_at(0)), 32'd7);

        // Reset dropped while an SW sits in MEM
        push_job(32'hAC030008, 0, 4);
        guard = 0;
        cycle(1'b1);
        while (!(plan[idx] == 3 && !need_new) && guard < 20) begin
            cycle(1'b1);
            guard++;
        end
        check("rst_reached_mem", 32'(plan[idx]), 32'd3);
        cycle(1'b0);
        check("rst_mem_dm_wen", 32'(trace[trace.size() - 1].wen), 32'd0);
        cycle(1'b1);
        check("rst_restart_if", 32'(obs_state), 32'd0);
        check("rst_inst_cnt",   obs_ins,        32'd0);

        // Ten ALU instructions at full readiness straight out of reset
        cycle(1'b0);
        for (int k = 0; k < 10; k++) begin
            case (k % 3)
                0:       push_job(32'h00221821, 0, 0);
                1:       push_job(32'h3C010005, 0, 0);
                default: push_job(32'h00000000, 0, 0);
            endcase
        end
        run_jobs(10);
        cycle(1'b1);
        check("perf_cycle_cnt", obs_cyc, PERF ? 32'd40 : 32'd0);
        check("perf_inst_cnt",  obs_ins, PERF ? 32'd10 : 32'd0);

        // Randomized traffic with occasional resets
        repeat (3000) cycle(($urandom_range(0, 249) != 0) ? 1'b1 : 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 clk  input  1  clock; all state updates on rising edge.
REQ-002 resetn  input  1  reset, synchronous, active-low.
REQ-003 inst  input  32  instruction register contents from the datapath; decoded only in ID.
REQ-004 imem_ready  input  1  instruction fetch data valid this cycle.
REQ-005 dmem_ready  input  1  data memory access completes this cycle.
REQ-006 ir_wen  output  1  load instruction register.
REQ-007 pc_wen  output  1  update PC; the datapath selects the branch/jump target or PC+4.
REQ-008 rf_wen  output  1  register file write strobe.
REQ-009 dm_req  output  1  data memory access request.
REQ-010 dm_wen  output  4  data memory byte write enables.
REQ-011 state  output  3  current state: IF=0, ID=1, EX=2, MEM=3, WB=4.
REQ-012 inst_done  output  1  one-cycle pulse in the final cycle of each instruction.
REQ-013 cycle_cnt  output  32  cycles since reset (see Configuration).
REQ-014 inst_cnt  output  32  retired instructions since reset (see Configuration).

Function
REQ-015 Decode classes: BR = J(op 000010), BEQ(000100), BNE(000101); MEMLD = LW(100011); MEMST = SW(101011).
REQ-016 Decode class ALU = ADDIU(001001), LUI(001111), LLI(100010), plus op=0 with funct in {100001, 100011, 101010, 100100, 100111, 100101, 100110, 010001, 010101} and sa=0, plus SLL/SRL (funct 000000/000010) with rs=0.
REQ-017 Any other encoding is class INV and executes as a NOP.
REQ-018 IF: ir_wen=1 while imem_ready=1; stay in IF while imem_ready=0; go to ID when imem_ready=1.
REQ-019 ID, BR or INV: pc_wen=1 and inst_done=1; next state IF.
REQ-020 ID, all other classes: next state EX.
REQ-021 EX: one cycle; MEMLD/MEMST go to MEM; ALU goes to WB.
REQ-022 MEM: dm_req=1; dm_wen=4'hF only for MEMST; hold in MEM while dmem_ready=0.
REQ-023 MEM with dmem_ready=1: MEMST asserts pc_wen and inst_done and goes to IF; MEMLD goes to WB.
REQ-024 WB: rf_wen=1, pc_wen=1, inst_done=1; next state IF.
REQ-025 Each strobe asserts only in the states listed above; otherwise it is 0.
REQ-026 pc_wen asserts exactly once per instruction.
REQ-027 rf_wen asserts at most once per instruction.
REQ-028 Latencies with ready inputs held high: BR/INV 2 cycles, ALU 4 cycles, SW 4 cycles, LW 5 cycles.
REQ-029 Each cycle of imem_ready=0 in IF, or dmem_ready=0 in MEM, adds exactly one cycle to the instruction.
REQ-030 dmem_ready is ignored outside MEM; imem_ready is ignored outside IF.
REQ-031 Encodings 5-7 are unreachable; if entered, next state is IF and all strobes are 0.

Reset
REQ-032 While resetn=0 at a clock edge: state<=IF and counters<=0.
REQ-033 All write strobes (ir_wen, pc_wen, rf_wen, dm_req, dm_wen, inst_done) are combinationally forced to 0 while resetn=0.
REQ-034 Reset asserted mid-instruction abandons that instruction: no further strobes, inst_cnt is not incremented.
REQ-035 Fetch restarts in IF on the first cycle after resetn returns to 1.

Configuration
REQ-036 Macro MULTI_CYCLE_PERF_CNT_EN enables the performance counters.
REQ-037 When defined, cycle_cnt increments every cycle with resetn=1 and wraps 0xFFFFFFFF->0.
REQ-038 When defined, inst_cnt increments on each inst_done and wraps 0xFFFFFFFF->0.
REQ-039 When not defined, cycle_cnt and inst_cnt are constant 0 and no counter flops are built.
REQ-040 The macro does not change control behaviour.

Verification
REQ-041 ADDU (0x00221821), readies high: state 0,1,2,4, rf_wen=1 only in cycle 4; inst_cnt 0->1.
REQ-042 LW (0x8C030004) with dmem_ready low 2 cycles: MEM lasts 3 cycles with dm_req=1 and dm_wen=0; WB follows; total 7 cycles.
REQ-043 SW (0xAC030008): dm_wen=4'hF only in MEM; pc_wen in the MEM cycle with dmem_ready=1; rf_wen never asserts; 4 cycles.
REQ-044 BEQ (0x10220003), then inst=0xFFFFFFFF: each takes 2 cycles with pc_wen in ID; the INV never asserts rf_wen or dm_wen.
REQ-045 resetn dropped during MEM of an SW: dm_wen=0 that cycle; next state IF; inst_cnt=0.
REQ-046 With macro defined, after 10 ALU instructions at full readiness: cycle_cnt=40 and inst_cnt=10.
REQ-047 Without the macro, the same run leaves both counters at 0.
